meteor_field: RTL



---
 rtl/meteor_pkg.sv | 39 +++
 rtl/meteor_field_lfsr16.sv | 32 +++
 rtl/meteor_field.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/meteor_pkg.sv
// Shared types and constants for the meteor field: FSM states, slot payload, LFSR setup.
package meteor_pkg;

  localparam int unsigned COORD_W   = 10;
  localparam int unsigned SPEED_W   = 3;
  localparam int unsigned RND_W     = 14;
  localparam int unsigned LFSR_W    = 16;
  localparam int unsigned X_BASE    = 16;
  localparam int unsigned SIZE_BASE = 8;

  localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FROZEN = 2'd2
  } meteor_state_t;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] size;
    logic [SPEED_W-1:0] speed;
    logic               alive;
  } meteor_t;

  // Fresh meteor at the top row with position, size and speed drawn from the LFSR.
  function automatic meteor_t spawn_meteor(input logic [RND_W-1:0] rnd);
    meteor_t m;
    m.x     = COORD_W'(X_BASE) + COORD_W'(rnd[8:0]);
    m.y     = '0;
    m.size  = COORD_W'(SIZE_BASE) + COORD_W'({rnd[11:9], 1'b0});
    m.speed = SPEED_W'(1) + SPEED_W'(rnd[13:12]);
    m.alive = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/meteor_field_lfsr16.sv
// Free-running 16-bit Galois LFSR; exposes its low OUT_W bits as the random field.
module lfsr16
  import meteor_pkg::*;
#(
  parameter int unsigned OUT_W = RND_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  output logic [OUT_W-1:0] rnd_o
);

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q >> 1;
    if (lfsr_q[0]) begin
      lfsr_d = lfsr_d ^ LFSR_TAPS;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign rnd_o = lfsr_q[OUT_W-1:0];

endmodule

// File: rtl/meteor_field.sv
// Meteor field: spawns, moves and despawns meteors per frame and counts dodges.
// Build option METEOR_DIFFICULTY_RAMP_EN shortens the spawn gap as the score grows.
module meteor_field
  import meteor_pkg::*;
#(
  parameter int unsigned OBJ_NUM   = 4,
  parameter int unsigned SPAWN_GAP = 30,
  parameter int unsigned GAP_MIN   = 10,
  parameter int unsigned Y_MAX     = 479
) (
  input  logic               frame_clk,
  input  logic               Reset,
  input  logic               enable,
  input  logic               player_die,
  output logic [COORD_W-1:0] enemy_x     [OBJ_NUM],
  output logic [COORD_W-1:0] enemy_y     [OBJ_NUM],
  output logic [COORD_W-1:0] enemy_size  [OBJ_NUM],
  output logic               enemy_alive [OBJ_NUM],
  output logic [15:0]        score,
  output logic               frozen
);

  localparam int unsigned GAP_TOP = (SPAWN_GAP > GAP_MIN) ? SPAWN_GAP : GAP_MIN;
  localparam int unsigned GAP_W   = $clog2(GAP_TOP + 1);
  localparam int unsigned CNT_W   = $clog2(OBJ_NUM + 1);
  localparam int unsigned SUM_W   = COORD_W + 1;

  meteor_state_t      state_q;
  meteor_state_t      state_d;
  meteor_t            slot_q [OBJ_NUM];
  meteor_t            slot_d [OBJ_NUM];
  logic [GAP_W-1:0]   timer_q;
  logic [GAP_W-1:0]   timer_d;
  logic [GAP_W-1:0]   gap_q;
  logic [GAP_W-1:0]   gap_d;
  logic [15:0]        score_q;
  logic [15:0]        score_d;
  logic               frozen_q;
  logic               frozen_d;

  logic [RND_W-1:0]   rnd;
  logic [CNT_W-1:0]   despawn_cnt;
  logic               spawn_done;
  logic [SUM_W-1:0]   y_sum;
  logic [16:0]        score_sum;

  lfsr16 #(
    .OUT_W (RND_W)
  ) u_lfsr (
    .clk_i (frame_clk),
    .rst_i (Reset),
    .rnd_o (rnd)
  );

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Leaving the game (enable low) wins over a death in the same frame.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable) state_d = RUN;
      RUN: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (player_die) begin
          state_d = FROZEN;
        end
      end
      FROZEN:  if (!enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    slot_d      = slot_q;
    timer_d     = timer_q;
    gap_d       = gap_q;
    score_d     = score_q;
    frozen_d    = (state_d == FROZEN);
    despawn_cnt = '0;
    spawn_done  = 1'b0;
    y_sum       = '0;
    score_sum   = '0;

    case (state_q)
      IDLE: begin
        if (enable) begin
          score_d = '0;
          timer_d = gap_q;
        end
      end

      RUN: begin
        if (!enable) begin
          for (int unsigned i = 0; i < OBJ_NUM; i++) begin
            slot_d[i].alive = 1'b0;
          end
        end else if (!player_die) begin
          for (int unsigned i = 0; i < OBJ_NUM; i++) begin
            if (slot_q[i].alive) begin
              y_sum = {1'b0, slot_q[i].y} + SUM_W'(slot_q[i].speed);
              if (y_sum > SUM_W'(Y_MAX)) begin
                slot_d[i].alive = 1'b0;
                despawn_cnt     = despawn_cnt + CNT_W'(1);
              end else begin
                slot_d[i].y = y_sum[COORD_W-1:0];
              end
            end
          end

          // Only slots dead at frame start are eligible, so a slot freed above waits a frame.
          if (timer_q == '0) begin
            for (int unsigned i = 0; i < OBJ_NUM; i++) begin
              if (!slot_q[i].alive && !spawn_done) begin
                slot_d[i]  = spawn_meteor(rnd);
                spawn_done = 1'b1;
              end
            end
            if (spawn_done) begin
              timer_d = gap_q;
            end
          end else begin
            timer_d = timer_q - GAP_W'(1);
          end

          score_sum = {1'b0, score_q} + 17'(despawn_cnt);
          score_d   = score_sum[16] ? 16'hFFFF : score_sum[15:0];

`ifdef METEOR_DIFFICULTY_RAMP_EN
          if (score_d[15:3] != score_q[15:3]) begin
            if (32'(gap_q) >= GAP_MIN + 2) begin
              gap_d = gap_q - GAP_W'(2);
            end else begin
              gap_d = GAP_W'(GAP_MIN);
            end
          end
`else
          gap_d = gap_q;
`endif
        end
      end

      FROZEN: begin
        if (!enable) begin
          for (int unsigned i = 0; i < OBJ_NUM; i++) begin
            slot_d[i].alive = 1'b0;
          end
        end
      end

      default: ;
    endcase
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      for (int unsigned i = 0; i < OBJ_NUM; i++) begin
        slot_q[i] <= '0;
      end
      timer_q  <= GAP_W'(SPAWN_GAP);
      gap_q    <= GAP_W'(SPAWN_GAP);
      score_q  <= '0;
      frozen_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < OBJ_NUM; i++) begin
        slot_q[i] <= slot_d[i];
      end
      timer_q  <= timer_d;
      gap_q    <= gap_d;
      score_q  <= score_d;
      frozen_q <= frozen_d;
    end
  end

  for (genvar g = 0; g < OBJ_NUM; g++) begin : g_out
    assign enemy_x[g]     = slot_q[g].x;
    assign enemy_y[g]     = slot_q[g].y;
    assign enemy_size[g]  = slot_q[g].size;
    assign enemy_alive[g] = slot_q[g].alive;
  end

  assign score  = score_q;
  assign frozen = frozen_q;

endmodule
